// File: rtl/dmem_pkg.sv
// Shared types, funct3 encodings and request-legality helpers for the
// data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only know B/H/W; loads additionally allow the unsigned forms.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic sized;
        sized = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (we) return !sized;
        return !(sized || (f3 == F3_BU) || (f3 == F3_HU));
    endfunction

    // Halfwords need even addresses, words need 4-byte alignment.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        if ((f3 == F3_H) || (f3 == F3_HU)) return lo[0];
        if (f3 == F3_W) return (lo != 2'b00);
        return 1'b0;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Combinational load aligner: shifts the addressed byte/half down to bit 0
// and sign- or zero-extends it according to funct3.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] shifted;

    // Select and extend the addressed lanes.
    always_comb begin
        shifted = i_word >> {i_off, 3'b000};
        case (i_funct3)
            F3_B:    o_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    o_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    o_data = shifted;
            F3_BU:   o_data = {24'd0, shifted[7:0]};
            F3_HU:   o_data = {16'd0, shifted[15:0]};
            default: o_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store at a time, a fixed
// number of wait states before the RAM access, and a held response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int P_DATA_WIDTH  = 32,
    parameter int P_ADDR_WIDTH  = 8,
    parameter int P_WAIT_CYCLES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [2:0]              i_req_funct3,
    input  logic [P_ADDR_WIDTH-1:0] i_req_addr,
    input  logic [P_DATA_WIDTH-1:0] i_req_wdata,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [P_DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                    o_rsp_err
);

    localparam int AW    = P_ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** AW;
    localparam int CW    = (P_WAIT_CYCLES > 0) ? $clog2(P_WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] WAIT_INIT = CW'(P_WAIT_CYCLES);

    dmem_state_t             state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    we_q;
    logic [2:0]              f3_q;
    logic [P_ADDR_WIDTH-1:0] addr_q;
    logic [P_DATA_WIDTH-1:0] wdata_q;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [P_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [P_DATA_WIDTH-1:0] ram_q [DEPTH];

    logic                    accept, req_bad, access;
    logic [AW-1:0]           widx;
    logic [P_DATA_WIDTH-1:0] load_data, wlanes;
    logic [3:0]              be;

    assign o_req_ready = (state_q == IDLE);
    assign accept      = i_req_valid & o_req_ready;
    assign req_bad     = f3_illegal(i_req_we, i_req_funct3) | misaligned(i_req_funct3, i_req_addr[1:0]);
    assign access      = (state_q == WAIT) && (cnt_q == '0);
    assign widx        = addr_q[P_ADDR_WIDTH-1:2];

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = err_q;

    dmem_load_align u_align (
        .i_word   (ram_q[widx]),
        .i_off    (addr_q[1:0]),
        .i_funct3 (f3_q),
        .o_data   (load_data)
    );

    // Store lane enables and replicated store data; only legal B/H/W stores reach WAIT.
    always_comb begin
        be     = 4'b1111;
        wlanes = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                be     = 4'b0001 << addr_q[1:0];
                wlanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be     = 4'b0011 << addr_q[1:0];
                wlanes = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    // Next-state logic for the FSM, wait counter and response registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            IDLE: if (accept) begin
                if (req_bad) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rdata_d     = '0;
                    err_d       = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rdata_d     = we_q ? '0 : load_data;
                    err_d       = 1'b0;
                end
            end
            RESP: if (i_rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and response state; reset overrides everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Request capture at acceptance; no reset needed, only read while busy.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            we_q    <= i_req_we;
            f3_q    <= i_req_funct3;
            addr_q  <= i_req_addr;
            wdata_q <= i_req_wdata;
        end
    end

    // Byte-lane RAM write; a store caught by reset is dropped.
    always_ff @(posedge i_clk) begin
        if (!i_rst && access && we_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ram_q[widx][b*8 +: 8] <= wlanes[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a 2-wait-state instance and a
// 0-wait-state instance, expected responses queued at issue time.
module tb_dmem_responder;
    import dmem_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [1:0]       req_we = '0;
    logic [1:0][2:0]  req_f3 = '0;
    logic [1:0][7:0]  req_addr = '0;
    logic [1:0][31:0] req_wdata = '0;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready = '0;
    logic [1:0][31:0] rsp_rdata;
    logic [1:0]       rsp_err;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_responder #(.P_DATA_WIDTH(32), .P_ADDR_WIDTH(8), .P_WAIT_CYCLES(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]), .i_req_we(req_we[0]),
        .i_req_funct3(req_f3[0]), .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
        .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0])
    );

    dmem_responder #(.P_DATA_WIDTH(32), .P_ADDR_WIDTH(8), .P_WAIT_CYCLES(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]), .i_req_we(req_we[1]),
        .i_req_funct3(req_f3[1]), .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
        .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one request at a negedge; it is accepted at the following posedge.
    task automatic send(input int s, input logic we, input logic [2:0] f3,
                        input logic [7:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_valid[s] = 1'b1;
        req_we[s]    = we;
        req_f3[s]    = f3;
        req_addr[s]  = addr;
        req_wdata[s] = wd;
        chk("req_ready_before_accept", {31'd0, req_ready[s]}, 32'd1);
        @(posedge clk);
        #1 req_valid[s] = 1'b0;
    endtask

    // Wait for the response, compare against the queue head, then handshake.
    task automatic collect(input int s, input string tag);
        exp_t e;
        int   k;
        e = sb.pop_front();
        k = 0;
        @(negedge clk);
        while (!rsp_valid[s] && k < 20) begin
            k++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, k, e.lat);
        chk({tag, "_rdata"}, rsp_rdata[s], e.rdata);
        chk({tag, "_err"}, {31'd0, rsp_err[s]}, {31'd0, e.err});
        rsp_ready[s] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[s] = 1'b0;
        @(negedge clk);
        chk({tag, "_valid_cleared"}, {31'd0, rsp_valid[s]}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, req_ready[s]}, 32'd1);
    endtask

    task automatic req(input int s, input string tag, input logic we, input logic [2:0] f3,
                       input logic [7:0] addr, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int el);
        send(s, we, f3, addr, wd);
        sb.push_back('{rdata: er, err: ee, lat: el});
        collect(s, tag);
    endtask

    initial begin
        exp_t e;
        int   k;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        chk("rst_rdata", rsp_rdata[0], 32'd0);
        chk("rst_err", {31'd0, rsp_err[0]}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready[0]}, 32'd1);

        // Basic word store/load, 2 wait states -> valid 3 edges after accept.
        req(0, "sw10", 1'b1, F3_W, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0, 3);
        req(0, "lw10", 1'b0, F3_W, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);
        // Byte store into the top lane, then sign/zero-extended reads.
        req(0, "sb13", 1'b1, F3_B, 8'h13, 32'hFFFFFF80, 32'h0, 1'b0, 3);
        req(0, "lb13", 1'b0, F3_B, 8'h13, 32'h0, 32'hFFFFFF80, 1'b0, 3);
        req(0, "lbu13", 1'b0, F3_BU, 8'h13, 32'h0, 32'h00000080, 1'b0, 3);
        req(0, "lw10b", 1'b0, F3_W, 8'h10, 32'h0, 32'h80ADBEEF, 1'b0, 3);
        req(0, "lh12", 1'b0, F3_H, 8'h12, 32'h0, 32'hFFFF80AD, 1'b0, 3);
        // Error paths: misaligned half, illegal store size, illegal load funct3.
        req(0, "lh11_err", 1'b0, F3_H, 8'h11, 32'h0, 32'h0, 1'b1, 0);
        req(0, "st100_err", 1'b1, 3'b100, 8'h10, 32'h11111111, 32'h0, 1'b1, 0);
        req(0, "lw_misal", 1'b0, F3_W, 8'h12, 32'h0, 32'h0, 1'b1, 0);
        req(0, "ld011_err", 1'b0, 3'b011, 8'h10, 32'h0, 32'h0, 1'b1, 0);
        req(0, "lw10_unch", 1'b0, F3_W, 8'h10, 32'h0, 32'h80ADBEEF, 1'b0, 3);

        // Backpressure: hold the response 5 cycles while a new request waits.
        send(0, 1'b0, F3_W, 8'h10, 32'h0);
        sb.push_back('{rdata: 32'h80ADBEEF, err: 1'b0, lat: 3});
        e = sb.pop_front();
        k = 0;
        @(negedge clk);
        while (!rsp_valid[0] && k < 20) begin
            k++;
            @(negedge clk);
        end
        chk("stall_latency", k, e.lat);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_f3[0]    = F3_BU;
        req_addr[0]  = 8'h10;
        sb.push_back('{rdata: 32'h000000EF, err: 1'b0, lat: 3});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, rsp_valid[0]}, 32'd1);
            chk("stall_rdata", rsp_rdata[0], e.rdata);
            chk("stall_err", {31'd0, rsp_err[0]}, 32'd0);
            chk("stall_req_ready", {31'd0, req_ready[0]}, 32'd0);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[0] = 1'b0;
        chk("stall_post_hs_ready", {31'd0, req_ready[0]}, 32'd1);
        chk("stall_post_hs_valid", {31'd0, rsp_valid[0]}, 32'd0);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        collect(0, "stall_next_lbu");

        // Reset during a pending store: the write must be dropped.
        req(0, "sw20_zero", 1'b1, F3_W, 8'h20, 32'h0, 32'h0, 1'b0, 3);
        send(0, 1'b1, F3_W, 8'h20, 32'h12345678);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        chk("rst2_rdata", rsp_rdata[0], 32'd0);
        chk("rst2_err", {31'd0, rsp_err[0]}, 32'd0);
        chk("rst2_req_ready", {31'd0, req_ready[0]}, 32'd1);
        repeat (4) @(negedge clk);
        req(0, "lw20_after_rst", 1'b0, F3_W, 8'h20, 32'h0, 32'h0, 1'b0, 3);

        // Zero-wait-state instance.
        req(1, "w0_sh22", 1'b1, F3_H, 8'h22, 32'h0000BEEF, 32'h0, 1'b0, 1);
        req(1, "w0_lhu22", 1'b0, F3_HU, 8'h22, 32'h0, 32'h0000BEEF, 1'b0, 1);
        req(1, "w0_lh22", 1'b0, F3_H, 8'h22, 32'h0, 32'hFFFFBEEF, 1'b0, 1);
        req(1, "w0_sh_err", 1'b1, F3_H, 8'h23, 32'h0, 32'h0, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
